data_sram_resp: RTL and testbench

Responder end of the CPU data-SRAM port. It accepts load and store requests from the pipeline over a req/addr_ok/data_ok handshake and queues them in order. Each request is executed against a byte-writable word memory after a programmable latency, and the result is returned as a one-cycle data_ok pulse with rdata. It sits outside mycpu_top, standing in for the data RAM the MEM stage reads through data_sram_rdata.

---
 rtl/data_sram_resp_pkg.sv | 19 +
 rtl/ds_req_fifo.sv | 58 +++++
 rtl/data_sram_resp.sv | 117 +++++++++++
 tb/tb_data_sram_resp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared types and field widths for the data-SRAM responder.
// A queue entry is packed as {wr, word index, wstrb, wdata}.
package data_sram_resp_pkg;

  localparam int DS_STRB_W = 4;
  localparam int DS_DATA_W = 32;
  localparam int DS_LAT_W  = 3;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_WAIT = 2'd1,
    DS_RESP = 2'd2
  } ds_state_e;

  function automatic int ds_req_wd(input int addr_w);
    return 1 + addr_w + DS_STRB_W + DS_DATA_W;
  endfunction

endpackage

// File: rtl/ds_req_fifo.sv
// Circular request queue with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module ds_req_fifo #(
  parameter int W     = 47,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = slots[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: queues load/store requests in order and answers each
// with a one-cycle data_ok pulse LATENCY cycles after it reaches the head.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int REQ_W = ds_req_wd(ADDR_W);
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [DS_LAT_W-1:0] LAT_INIT = DS_LAT_W'(LATENCY - 1);
  localparam ds_state_e FIRST_ST = (LATENCY == 1) ? DS_RESP : DS_WAIT;

  logic [REQ_W-1:0]  push_data, head;
  logic [CNT_W-1:0]  count;
  logic              full, empty, accept, resp;
  logic              head_wr;
  logic [ADDR_W-1:0] head_idx;
  logic [3:0]        head_wstrb;
  logic [31:0]       head_wdata;
  logic              unused_addr_bits;

  ds_state_e           state_q, state_d;
  logic [DS_LAT_W-1:0] cnt_q, cnt_d;

  logic [31:0] mem [2**ADDR_W];

  assign data_sram_addr_ok = !full && !reset;
  assign accept            = data_sram_req && data_sram_addr_ok;
  assign push_data         = {data_sram_wr, data_sram_addr[ADDR_W+1:2],
                              data_sram_wstrb, data_sram_wdata};
  assign unused_addr_bits  = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  ds_req_fifo #(
    .W     (REQ_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (resp),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign head_wr    = head[REQ_W-1];
  assign head_idx   = head[REQ_W-2 -: ADDR_W];
  assign head_wstrb = head[DS_DATA_W +: DS_STRB_W];
  assign head_wdata = head[DS_DATA_W-1:0];

  // An entry arriving this cycle counts as present so LATENCY=1 answers next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp    = 1'b0;
    unique case (state_q)
      DS_IDLE: begin
        if (!empty || accept) begin
          state_d = FIRST_ST;
          cnt_d   = LAT_INIT;
        end
      end
      DS_WAIT: begin
        cnt_d = cnt_q - DS_LAT_W'(1);
        if (cnt_q == DS_LAT_W'(1)) state_d = DS_RESP;
      end
      DS_RESP: begin
        resp = 1'b1;
        if ((count != CNT_W'(1)) || accept) begin
          state_d = FIRST_ST;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resp && head_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head_wstrb[i]) mem[head_idx][8*i +: 8] <= head_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_data_ok = resp;
  assign data_sram_rdata   = (resp && !head_wr) ? mem[head_idx] : 32'h0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one instance at LATENCY=1 and one at
// LATENCY=3, both QDEPTH=2, sharing clock and reset.
module tb_data_sram_resp;

  logic clk, reset;

  logic        req1, wr1, aok1, dok1;
  logic [3:0]  strb1;
  logic [31:0] addr1, wdata1, rdata1;

  logic        req3, wr3, aok3, dok3;
  logic [3:0]  strb3;
  logic [31:0] addr3, wdata3, rdata3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  data_sram_resp #(.ADDR_W(10), .LATENCY(1), .QDEPTH(2)) u_lat1 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req1),
    .data_sram_wr      (wr1),
    .data_sram_wstrb   (strb1),
    .data_sram_addr    (addr1),
    .data_sram_wdata   (wdata1),
    .data_sram_addr_ok (aok1),
    .data_sram_data_ok (dok1),
    .data_sram_rdata   (rdata1)
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(3), .QDEPTH(2)) u_lat3 (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req3),
    .data_sram_wr      (wr3),
    .data_sram_wstrb   (strb3),
    .data_sram_addr    (addr3),
    .data_sram_wdata   (wdata3),
    .data_sram_addr_ok (aok3),
    .data_sram_data_ok (dok3),
    .data_sram_rdata   (rdata3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request on the LATENCY=3 instance from an idle queue.
  task automatic do_req3(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp);
    int n;
    req3 = 1'b1; wr3 = wr; addr3 = addr; wdata3 = wdata; strb3 = strb;
    n = 0;
    while (!aok3 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_aok"}, 32'(aok3), 32'd1);
    tick();
    req3 = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (dok3) break;
      tick();
    end
    check({tag, "_lat"}, 32'(n), 32'd2);
    check({tag, "_rdata"}, rdata3, exp);
  endtask

  vec_t v1[6];
  logic [13:0] exp_aok, exp_dok;

  initial begin
    int idx, ridx;

    reset = 1'b1;
    req1 = 0; wr1 = 0; strb1 = 0; addr1 = 0; wdata1 = 0;
    req3 = 0; wr3 = 0; strb3 = 0; addr3 = 0; wdata3 = 0;

    v1[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    v1[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    v1[2] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h6, 32'h0};
    v1[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_33EF};
    v1[4] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0};
    v1[5] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D};

    exp_aok = 14'b11110010010011;
    exp_dok = 14'b01001001001000;

    repeat (2) tick();
    check("rst_aok1", 32'(aok1), 32'd0);
    check("rst_dok1", 32'(dok1), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_aok3", 32'(aok3), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_aok1", 32'(aok1), 32'd1);
    tick();

    // Back-to-back LATENCY=1 traffic: each response lands the cycle after its accept.
    for (int i = 0; i < 6; i++) begin
      req1 = 1'b1; wr1 = v1[i].wr; addr1 = v1[i].addr;
      wdata1 = v1[i].wdata; strb1 = v1[i].strb;
      check($sformatf("l1_aok_%0d", i), 32'(aok1), 32'd1);
      tick();
      check($sformatf("l1_dok_%0d", i), 32'(dok1), 32'd1);
      check($sformatf("l1_rdata_%0d", i), rdata1, v1[i].exp);
    end
    req1 = 1'b0;
    tick();
    check("l1_idle_dok", 32'(dok1), 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_req3($sformatf("pre_st%0d", i), 1'b1, 32'(i * 4), 32'h0BAD_0000 + 32'(i),
              4'hF, 32'h0);
    end
    tick();

    // req held high for four loads on the LATENCY=3, depth-2 queue.
    idx = 0;
    ridx = 0;
    for (int c = 0; c < 14; c++) begin
      req3 = (idx < 4); wr3 = 1'b0; addr3 = 32'(idx * 4); strb3 = 4'h0;
      check($sformatf("q_aok_c%0d", c), 32'(aok3), 32'(exp_aok[c]));
      check($sformatf("q_dok_c%0d", c), 32'(dok3), 32'(exp_dok[c]));
      if (dok3) begin
        check($sformatf("q_rdata_%0d", ridx), rdata3, 32'h0BAD_0000 + 32'(ridx));
        ridx++;
      end
      if (req3 && aok3) idx++;
      tick();
    end
    req3 = 1'b0;
    check("q_resp_count", 32'(ridx), 32'd4);

    // Two requests in flight when reset hits; the queued store must never land.
    tick();
    req3 = 1'b1; wr3 = 1'b1; addr3 = 32'h0; wdata3 = 32'hFFFF_FFFF; strb3 = 4'hF;
    tick();
    wr3 = 1'b0; addr3 = 32'h4; strb3 = 4'h0;
    tick();
    req3 = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_aok3", 32'(aok3), 32'd0);
    check("mid_rst_dok3", 32'(dok3), 32'd0);
    check("mid_rst_aok1", 32'(aok1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("in_rst_dok3_%0d", i), 32'(dok3), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("after_rst_dok3_%0d", i), 32'(dok3), 32'd0);
    end
    do_req3("ret_ld0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_0000);

    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0; strb1 = 4'h0;
    tick();
    req1 = 1'b0;
    check("ret_l1_dok", 32'(dok1), 32'd1);
    check("ret_l1_rdata", rdata1, 32'hCAFE_F00D);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
